// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding and default width.
package div_pkg;
  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/div_sub_stage.sv
// Combinational trial subtractor a - b, built as a + ~b + 1 over a ripple of full-adder cells.
module div_sub_stage #(
  parameter int W = 9
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff,
  output logic         borrow
);
  logic [W:0]   carry;
  logic [W-1:0] nb;

  assign nb       = ~b;
  assign carry[0] = 1'b1;

  for (genvar i = 0; i < W; i++) begin : g_fa
    assign diff[i]      = a[i] ^ nb[i] ^ carry[i];
    assign carry[i + 1] = (a[i] & nb[i]) | (carry[i] & (a[i] ^ nb[i]));
  end

  // No carry out of the top cell means b was larger than a.
  assign borrow = ~carry[W];
endmodule

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per cycle MSB first; done pulses WIDTH cycles
// after the accepting edge (same cycle for a zero divisor). start is ignored while busy.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             borrow;
  logic             qbit;
  logic [WIDTH-1:0] next_r;

  // dvd shifts dividend bits out of the top and quotient bits in at the bottom.
  assign shifted = {r, dvd[WIDTH-1]};

  div_sub_stage #(.W(WIDTH + 1)) u_sub (
    .a      (shifted),
    .b      ({1'b0, dvs}),
    .diff   (trial),
    .borrow (borrow)
  );

  // Trial sign and borrow agree since the partial remainder stays below 2*divisor.
  assign qbit   = ~trial[WIDTH] & ~borrow;
  assign next_r = qbit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      cnt         <= '0;
      r           <= '0;
      dvd         <= '0;
      dvs         <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        RUN: begin
          r   <= next_r;
          dvd <= {dvd[WIDTH-2:0], qbit};
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state     <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            quotient  <= {dvd[WIDTH-2:0], qbit};
            remainder <= next_r;
          end
        end
        default: begin
          if (start) begin
            dvs <= divisor;
            dvd <= dividend;
            r   <= '0;
            cnt <= '0;
            if (divisor == '0) begin
              state       <= DONE;
              done        <= 1'b1;
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              state       <= RUN;
              busy        <= 1'b1;
              div_by_zero <= 1'b0;
            end
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench: arithmetic reference model checked every cycle, plus directed literal cases.
module tb_seq_divider;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: counts busy cycles left, results from plain / and %.
  int           m_left = 0;
  bit           m_done = 1'b0;
  bit           m_z = 1'b0;
  logic [W-1:0] m_q = '0;
  logic [W-1:0] m_r = '0;
  logic [W-1:0] p_q = '0;
  logic [W-1:0] p_r = '0;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_left = 0; m_done = 1'b0; m_q = '0; m_r = '0; m_z = 1'b0;
    end else if (m_left > 0) begin
      m_left--;
      m_done = (m_left == 0);
      if (m_done) begin
        m_q = p_q;
        m_r = p_r;
      end
    end else if (start) begin
      if (divisor == 0) begin
        m_done = 1'b1; m_q = '1; m_r = dividend; m_z = 1'b1;
      end else begin
        m_left = W; m_done = 1'b0; m_z = 1'b0;
        p_q = dividend / divisor;
        p_r = dividend % divisor;
      end
    end else begin
      m_done = 1'b0;
    end
  end

  always @(negedge clk) begin
    chk("busy", busy, m_left > 0);
    chk("done", done, m_done);
    chk("quotient", quotient, m_q);
    chk("remainder", remainder, m_r);
    chk("div_by_zero", div_by_zero, m_z);
    chk("busy_done_excl", busy & done, 0);
  end

  task automatic wait_done(output int lat, output int bc);
    bit got = 1'b0;
    lat = 0;
    bc = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (done) got = 1'b1;
      else begin
        if (busy) bc++;
        lat++;
      end
    end
    chk("done_seen", got, 1);
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input int eq, input int er, input int ez, input int elat);
    int lat, bc;
    @(posedge clk); #1;
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk); #1;
    start = 1'b0; dividend = W'($urandom); divisor = W'($urandom);
    wait_done(lat, bc);
    chk("op_quotient", quotient, eq);
    chk("op_remainder", remainder, er);
    chk("op_dbz", div_by_zero, ez);
    chk("op_latency", lat, elat);
    chk("op_busy_cycles", bc, elat);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, bc, ndone;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    chk("rst_dbz", div_by_zero, 0);
    @(posedge clk); #1; rst = 1'b0;

    do_op(8'd100, 8'd7,   14,  2, 0, 8);
    do_op(8'd255, 8'd1,  255,  0, 0, 8);
    do_op(8'd7,   8'd200,  0,  7, 0, 8);
    do_op(8'd5,   8'd0,  255,  5, 1, 0);
    do_op(8'd100, 8'd7,   14,  2, 0, 8);

    // Back-to-back with a start pulse injected mid-run.
    @(posedge clk); #1;
    start = 1'b1; dividend = 8'd100; divisor = 8'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk); #1;
    start = 1'b1; dividend = 8'd3; divisor = 8'd1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat, bc);
    chk("b2b_first_q", quotient, 14);
    chk("b2b_first_r", remainder, 2);
    start = 1'b1; dividend = 8'd81; divisor = 8'd9;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("b2b_no_idle", busy, 1);
    wait_done(lat, bc);
    chk("b2b_second_q", quotient, 9);
    chk("b2b_second_r", remainder, 0);
    chk("b2b_second_lat", lat, 7);

    // Reset in the middle of step 4 of 200/3.
    @(posedge clk); #1;
    start = 1'b1; dividend = 8'd200; divisor = 8'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_quotient", quotient, 0);
    chk("midrst_remainder", remainder, 0);
    chk("midrst_dbz", div_by_zero, 0);
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("midrst_no_done", ndone, 0);
    do_op(8'd200, 8'd3, 66, 2, 0, 8);

    // Random soak: random start density, operands, occasional reset.
    for (int i = 0; i < 12000; i++) begin
      @(posedge clk); #1;
      start    = ($urandom_range(0, 3) != 0);
      dividend = W'($urandom);
      case ($urandom_range(0, 7))
        0:       divisor = '0;
        1:       divisor = 8'd1;
        2:       divisor = W'($urandom_range(1, 15));
        default: divisor = W'($urandom);
      endcase
      rst = ($urandom_range(0, 999) == 0);
    end
    @(posedge clk); #1;
    start = 1'b0; rst = 1'b0;
    repeat (12) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, giving the operand and result width in bits (legal range 2..32).
REQ-002 SHALL provide port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL provide port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL provide port start, input, 1 bit: request to begin a division.
REQ-005 SHALL provide port dividend, input, WIDTH bits: unsigned numerator, sampled on the accepting edge.
REQ-006 SHALL provide port divisor, input, WIDTH bits: unsigned denominator, sampled on the accepting edge.
REQ-007 SHALL provide port busy, output, 1 bit: high while iterating.
REQ-008 SHALL provide port done, output, 1 bit: single-cycle pulse marking results valid.
REQ-009 SHALL provide port quotient, output, WIDTH bits: result quotient.
REQ-010 SHALL provide port remainder, output, WIDTH bits: result remainder.
REQ-011 SHALL provide port div_by_zero, output, 1 bit: flag for the last completed operation.

Function
REQ-012 SHALL implement a three-state FSM with states IDLE, RUN and DONE.
REQ-013 SHALL accept start only in IDLE or DONE, latching both operands, clearing the partial remainder and iteration counter, and entering RUN; start SHALL be ignored in RUN.
REQ-014 SHALL perform one restoring step per RUN cycle, MSB first:
- R = {R[WIDTH-1:0], next dividend bit}, held as WIDTH+1 bits.
- trial = R + ~{0,divisor} + 1, a subtract formed as invert plus carry-in of 1.
- If trial bit WIDTH is 0: R = trial and quotient bit = 1; otherwise R is kept and quotient bit = 0.
REQ-015 SHALL leave RUN after exactly WIDTH steps and enter DONE.
REQ-016 SHALL hold done=1 only while in DONE (one cycle), then return to IDLE unless start is high.
REQ-017 SHALL assert done in the cycle after edge E0+WIDTH, where E0 is the accepting edge; latency is WIDTH cycles.
REQ-018 SHALL drive busy=1 exactly while in RUN, and never drive busy and done high together.
REQ-019 On divisor=0 at acceptance, SHALL bypass RUN and go directly to DONE, with quotient all ones, remainder = dividend and div_by_zero=1.
REQ-020 SHALL clear div_by_zero on the next accepted start with a nonzero divisor.
REQ-021 SHALL keep quotient, remainder and div_by_zero stable from done until the next accepting edge, and SHALL NOT expose intermediate values on them.
REQ-022 Start high in DONE SHALL be accepted on that edge, giving back-to-back operation with no IDLE cycle.
REQ-023 Operand changes after the accepting edge SHALL have no effect on the operation in progress.

Reset
REQ-024 While rst is high, SHALL force: state IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, counter=0.
REQ-025 Reset asserted mid-RUN SHALL abort the operation with no done pulse; the first start after deassertion SHALL behave as from power-up.

Structure
REQ-026 SHALL place the FSM state encoding (IDLE=0, RUN=1, DONE=2) and the default WIDTH in shared package div_pkg.
REQ-027 SHALL isolate the combinational WIDTH+1-bit trial subtractor in one sub-module, div_sub_stage (inputs a, b; outputs diff and borrow), built from a ripple of full-adder cells.

Verification
REQ-028 WIDTH=8, 100/7 -> quotient=14, remainder=2, div_by_zero=0; done in the cycle after edge E0+8, and busy high for exactly 8 cycles.
REQ-029 255/1 -> quotient=255, remainder=0; also 7/200 -> quotient=0, remainder=7.
REQ-030 5/0 -> quotient=255, remainder=5, div_by_zero=1; done in the cycle after E0, and busy never high.
REQ-031 Run 100/7, then assert start in the DONE cycle with 81/9 -> second result quotient=9, remainder=0, with no IDLE cycle between; a start pulse injected during RUN is ignored.
REQ-032 Assert rst at RUN step 4 of 200/3 -> all outputs read 0 and no done pulse; a following 200/3 yields quotient=66, remainder=2.
REQ-033 Random-operand soak of 10,000 pairs -> quotient*divisor+remainder == dividend and remainder < divisor for every nonzero divisor.
